// File: rtl/pwm_ctrl.sv
// Memory-mapped 8-bit PWM controller with double-buffered period/duty and a sticky done flag.
// Define PWM_PRESCALE_EN to add the CTRL[15:8] clock prescaler.
module pwm_ctrl #(
  parameter logic [7:0] RESET_PERIOD = 8'hFF,
  parameter logic [7:0] RESET_DUTY   = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        pwm_out,
  output logic        period_irq
);

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPeriod = 2'd1;
  localparam logic [1:0] AddrDuty   = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  logic       en_q, en_d;
  logic [7:0] period_reg_q, period_reg_d;
  logic [7:0] duty_reg_q, duty_reg_d;
  logic [7:0] period_act_q, period_act_d;
  logic [7:0] duty_act_q, duty_act_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       pwm_q, pwm_d;

  logic       ctrl_wr, period_wr, duty_wr, status_wr;
  logic       tick, wrap, en_rise, load;
  logic [7:0] prescale_rd;

  assign ctrl_wr   = we && (addr == AddrCtrl);
  assign period_wr = we && (addr == AddrPeriod);
  assign duty_wr   = we && (addr == AddrDuty);
  assign status_wr = we && (addr == AddrStatus);

`ifdef PWM_PRESCALE_EN
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] pre_cnt_q, pre_cnt_d;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[31:16];
  assign tick         = (pre_cnt_q == prescale_q);
  assign prescale_rd  = prescale_q;

  // A prescale write lands immediately; pre_cnt keeps running.
  always_comb begin
    prescale_d = ctrl_wr ? wdata[15:8] : prescale_q;
    pre_cnt_d  = 8'd0;
    if (en_q) begin
      pre_cnt_d = tick ? 8'd0 : pre_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= 8'd0;
      pre_cnt_q  <= 8'd0;
    end else begin
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
    end
  end
`else
  logic unused_wdata;

  assign unused_wdata = ^wdata[31:8];
  assign tick         = 1'b1;
  assign prescale_rd  = 8'h00;
`endif

  // Counting follows the registered enable, so the enable-write cycle only resets cnt.
  assign wrap    = en_q && tick && (cnt_q == period_act_q);
  assign en_rise = ctrl_wr && wdata[0] && !en_q;
  assign load    = wrap || en_rise;

  always_comb begin
    en_d         = ctrl_wr ? wdata[0] : en_q;
    period_reg_d = period_wr ? wdata[7:0] : period_reg_q;
    duty_reg_d   = duty_wr ? wdata[7:0] : duty_reg_q;

    // Shadows sample the pre-edge buffer values, so a write on a load edge waits a period.
    period_act_d = load ? period_reg_q : period_act_q;
    duty_act_d   = load ? duty_reg_q : duty_act_q;

    cnt_d = 8'd0;
    if (en_q) begin
      if (tick) begin
        cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end

    // Set beats a simultaneous clear.
    done_d = done_q;
    if (wrap) begin
      done_d = 1'b1;
    end else if (status_wr && wdata[0]) begin
      done_d = 1'b0;
    end

    pwm_d = en_q && (cnt_q < duty_act_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q         <= 1'b0;
      period_reg_q <= RESET_PERIOD;
      duty_reg_q   <= RESET_DUTY;
      period_act_q <= RESET_PERIOD;
      duty_act_q   <= RESET_DUTY;
      cnt_q        <= 8'd0;
      done_q       <= 1'b0;
      pwm_q        <= 1'b0;
    end else begin
      en_q         <= en_d;
      period_reg_q <= period_reg_d;
      duty_reg_q   <= duty_reg_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      pwm_q        <= pwm_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    unique case (addr)
      AddrCtrl:   rdata = {16'd0, prescale_rd, 7'd0, en_q};
      AddrPeriod: rdata = {24'd0, period_reg_q};
      AddrDuty:   rdata = {24'd0, duty_reg_q};
      AddrStatus: rdata = {16'd0, cnt_q, 7'd0, done_q};
    endcase
  end

  assign pwm_out    = pwm_q;
  assign period_irq = done_q;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Self-checking bench for pwm_ctrl: directed literal checks plus randomized bus traffic
// compared every cycle against a behavioural model.
module tb_pwm_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        pwm_out;
  logic        period_irq;

  int checks = 0;
  int errors = 0;

  pwm_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .pwm_out   (pwm_out),
    .period_irq(period_irq)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic       m_en   = 1'b0;
  logic [7:0] m_preg = 8'hFF;
  logic [7:0] m_dreg = 8'h00;
  logic [7:0] m_pact = 8'hFF;
  logic [7:0] m_dact = 8'h00;
  logic [7:0] m_cnt  = 8'h00;
  logic [7:0] m_psc  = 8'h00;
  logic       m_done = 1'b0;
  logic       m_pwm  = 1'b0;
`ifdef PWM_PRESCALE_EN
  logic [7:0] m_pre  = 8'h00;
`endif

  function automatic logic m_tick();
`ifdef PWM_PRESCALE_EN
    return m_pre == m_psc;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic m_wrap();
    return m_en && m_tick() && (m_cnt == m_pact);
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {16'h0, m_psc, 7'h0, m_en};
      2'd1:    return {24'h0, m_preg};
      2'd2:    return {24'h0, m_dreg};
      default: return {16'h0, m_cnt, 7'h0, m_done};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_en   <= 1'b0;
      m_preg <= 8'hFF;
      m_dreg <= 8'h00;
      m_pact <= 8'hFF;
      m_dact <= 8'h00;
      m_cnt  <= 8'h00;
      m_psc  <= 8'h00;
      m_done <= 1'b0;
      m_pwm  <= 1'b0;
`ifdef PWM_PRESCALE_EN
      m_pre  <= 8'h00;
`endif
    end else begin
      if (m_wrap() || (we && addr == 2'd0 && wdata[0] && !m_en)) begin
        m_pact <= m_preg;
        m_dact <= m_dreg;
      end
      if (!m_en) m_cnt <= 8'h00;
      else if (m_tick()) m_cnt <= m_wrap() ? 8'h00 : m_cnt + 8'd1;
`ifdef PWM_PRESCALE_EN
      if (!m_en) m_pre <= 8'h00;
      else m_pre <= m_tick() ? 8'h00 : m_pre + 8'd1;
      if (we && addr == 2'd0) m_psc <= wdata[15:8];
`endif
      m_pwm <= m_en && (m_cnt < m_dact);
      if (m_wrap()) m_done <= 1'b1;
      else if (we && addr == 2'd3 && wdata[0]) m_done <= 1'b0;
      if (we) begin
        case (addr)
          2'd0:    m_en   <= wdata[0];
          2'd1:    m_preg <= wdata[7:0];
          2'd2:    m_dreg <= wdata[7:0];
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_pwm_out", {31'b0, pwm_out}, {31'b0, m_pwm});
    chk("model_period_irq", {31'b0, period_irq}, {31'b0, m_done});
    chk("model_rdata", rdata, m_read(addr));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [7:0] d);
    wr(2'd0, 32'd0);
    wr(2'd1, {24'd0, p});
    wr(2'd2, {24'd0, d});
    wr(2'd0, 32'd1);
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h;
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    addr = 2'd0; #1 chk("rst_ctrl", rdata, 32'h0);
    addr = 2'd1; #1 chk("rst_period", rdata, 32'hFF);
    addr = 2'd2; #1 chk("rst_duty", rdata, 32'h0);
    chk("rst_pwm", {31'b0, pwm_out}, 32'h0);
    reset_n = 1'b1;
    cyc(1);

    // Basic 10-cycle period, 3 high
    load(8'd9, 8'd3);
    chk("basic_done_e0", {31'b0, period_irq}, 32'h0);
    cyc(9);
    chk("basic_done_e9", {31'b0, period_irq}, 32'h0);
    cyc(1);
    chk("basic_done_e10", {31'b0, period_irq}, 32'h1);
    count_high(20, h);
    chk("basic_high20", 32'(h), 32'd6);
    wr(2'd3, 32'h1);
    chk("basic_clear", {31'b0, period_irq}, 32'h0);
    cyc(8);
    wr(2'd3, 32'h1);
    chk("race_set_wins", {31'b0, period_irq}, 32'h1);

    load(8'd9, 8'd0);
    count_high(20, h);
    chk("duty0_high", 32'(h), 32'd0);

    load(8'd9, 8'hFF);
    cyc(1);
    count_high(20, h);
    chk("dutyff_high", 32'(h), 32'd20);

    // Async reset while running with pwm high
    reset_n = 1'b0;
    #1;
    addr = 2'd0; #1 chk("midrst_ctrl", rdata, 32'h0);
    addr = 2'd1; #1 chk("midrst_period", rdata, 32'hFF);
    chk("midrst_pwm", {31'b0, pwm_out}, 32'h0);
    chk("midrst_irq", {31'b0, period_irq}, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1);

    load(8'd0, 8'd0);
    cyc(1);
    wr(2'd3, 32'h1);
    chk("p0_irq", {31'b0, period_irq}, 32'h1);
    addr = 2'd3; #1 chk("p0_status", rdata, 32'h1);
    cyc(1);

    load(8'hFF, 8'h80);
    cyc(1);
    count_high(256, h);
    chk("p255_high", 32'(h), 32'd128);

    // Shadowing: mid-period and on-wrap duty writes
    load(8'd9, 8'd3);
    count_high(5, h);
    chk("shadow_cur", 32'(h), 32'd3);
    wr(2'd2, 32'd7);
    count_high(5, h);
    chk("shadow_rest", 32'(h), 32'd0);
    count_high(10, h);
    chk("shadow_next", 32'(h), 32'd7);
    cyc(8);
    wr(2'd2, 32'd2);
    count_high(10, h);
    chk("wrapwr_old", 32'(h), 32'd7);
    count_high(10, h);
    chk("wrapwr_new", 32'(h), 32'd2);

    // Disable mid-period, then re-enable with new registers
    load(8'd9, 8'd8);
    cyc(4);
    wr(2'd0, 32'd0);
    cyc(1);
    chk("dis_pwm", {31'b0, pwm_out}, 32'h0);
    addr = 2'd3; #1 chk("dis_cnt", {24'd0, rdata[15:8]}, 32'h0);
    cyc(1);
    wr(2'd1, 32'd5);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'd1);
    cyc(1);
    count_high(12, h);
    chk("reen_high", 32'(h), 32'd4);

`ifdef PWM_PRESCALE_EN
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h301);
    cyc(1);
    count_high(40, h);
    chk("psc_high", 32'(h), 32'd16);
    wr(2'd0, 32'd0);
`else
    wr(2'd0, 32'h300);
    addr = 2'd0; #1 chk("nopsc_ctrl", rdata, 32'h0);
    cyc(1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        we = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
      end else begin
        addr = 2'($urandom_range(0, 3));
        we = ($urandom_range(0, 5) == 0);
        wdata = $urandom;
        case (addr)
          2'd0: begin
            wdata[0] = ($urandom_range(0, 9) != 0);
            wdata[15:8] = 8'($urandom_range(0, 3));
          end
          2'd1: if ($urandom_range(0, 7) != 0) wdata[7:0] = 8'($urandom_range(0, 12));
          2'd2: if ($urandom_range(0, 7) != 0) wdata[7:0] = 8'($urandom_range(0, 14));
          default: ;
        endcase
        @(posedge clk);
        #1;
      end
    end
    we = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ctrl.md
Name: pwm_ctrl

Overview:
Memory-mapped PWM controller for the MIPS system's PWM peripheral. It owns an 8-bit period counter and double-buffered period/duty registers. It sequences the counter against the 8-bit magnitude comparison (counter < duty) to drive a PWM pin, and raises a sticky period-done flag. It sits on the processor's peripheral bus beside the existing I/O blocks.

Parameters:
- RESET_PERIOD, 8'hFF, PERIOD register value after reset.
- RESET_DUTY, 8'h00, DUTY register value after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  1  write strobe, sampled on the rising edge of clk.
- addr  in  2  register select: 0 CTRL, 1 PERIOD, 2 DUTY, 3 STATUS.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational from addr.
- pwm_out  out  1  registered PWM output.
- period_irq  out  1  level copy of STATUS.done.

Behaviour:
- Reset (async, reset_n=0):
  - en=0, period_reg=RESET_PERIOD, duty_reg=RESET_DUTY.
  - period_act=RESET_PERIOD, duty_act=RESET_DUTY, cnt=0, done=0, pwm_out=0, prescale=0, pre_cnt=0.
  - Reset asserted mid-period aborts immediately. No state survives.
- Register map. Unused bits read 0; writes to unused bits are ignored.
  - CTRL: bit0 en; bits15:8 prescale (only with the optional feature).
  - PERIOD: bits7:0 period_reg.
  - DUTY: bits7:0 duty_reg.
  - STATUS: bit0 done (write 1 to clear); bits15:8 live cnt (read-only).
- Shadowing:
  - Bus writes go to period_reg/duty_reg only.
  - period_act/duty_act load from period_reg/duty_reg only at a load event:
    - (a) wrap; or
    - (b) the en 0->1 transition.
  - A mid-period write never produces a glitched cycle.
- Tick: tick=1 every clk when the prescaler is absent. Otherwise see Optional Feature.
- Counter, while en=1:
  - On tick: if cnt==period_act, then cnt<=0 (wrap), load shadows, set done. Else cnt<=cnt+1.
  - 8-bit unsigned, so the period is period_act+1 ticks. period_act=0 gives cnt constantly 0, with a wrap every tick.
- Enable edge: on the cycle CTRL.en is written 0->1, cnt<=0, pre_cnt<=0 and shadows load. Counting starts the next cycle.
- Disable: en=0 forces cnt<=0 and pre_cnt<=0, and holds the shadows frozen. done keeps its value.
- Output: pwm_out <= en & (cnt < duty_act) (unsigned), with one clk latency relative to cnt/duty_act.
  - duty_act=0 gives pwm_out constantly 0.
  - duty_act > period_act gives pwm_out constantly 1 while enabled.
  - High time is duty_act ticks per period.
- done flag:
  - Set on wrap.
  - Cleared by a write to STATUS with wdata[0]=1.
  - A set on the same edge as a clear wins: done=1.
  - period_irq=done.
- Simultaneous events:
  - A PERIOD/DUTY write on the wrap edge: the shadows take the old period_reg/duty_reg value. The new value applies at the next load event.
  - A CTRL write of en=1 while already enabled has no load effect.

Optional Feature:
- Macro: PWM_PRESCALE_EN.
- Defined:
  - CTRL[15:8] is a writable 8-bit prescale register. pre_cnt counts 0..prescale and tick=1 when pre_cnt==prescale, then pre_cnt wraps to 0.
  - Counter rate is clk/(prescale+1). prescale=0 behaves identically to the feature being absent.
  - A prescale write takes effect immediately; pre_cnt is not reset.
- Undefined:
  - No prescale or pre_cnt storage. tick=1 every cycle.
  - CTRL[15:8] reads 0 and writes to it are ignored.

Test Plan:
1. Reset: hold reset_n=0 mid-operation -> rdata(CTRL)=0, PERIOD=8'hFF, DUTY=0, pwm_out=0, period_irq=0 asynchronously. Release -> all outputs stay 0.
2. Basic PWM: PERIOD=9, DUTY=3, en=1 -> pwm_out repeats 3 high / 7 low. done is set after 10 cycles; STATUS write 1 clears it.
3. Boundaries:
   - DUTY=0 -> pwm_out stuck 0.
   - DUTY=8'hFF with PERIOD=9 -> pwm_out stuck 1.
   - PERIOD=0 -> done set every cycle.
   - PERIOD=8'hFF, DUTY=8'h80 -> 128 high / 128 low, cnt wraps 255->0.
4. Shadowing: mid-period (cnt=5, PERIOD=9) write DUTY=7 -> the current period keeps 3-cycle high. The next period after wrap has 7-cycle high. Also write DUTY exactly on the wrap edge -> the old value is used for one more period.
5. Set/clear race: STATUS clear write on the wrap edge -> done=1 afterwards. Disable mid-period (cnt=4) -> cnt=0 and pwm_out=0 next cycle. Re-enable -> the period restarts from cnt=0 with the latest registers.
6. With PWM_PRESCALE_EN, prescale=3, PERIOD=4, DUTY=2 -> cnt advances every 4 clk. pwm_out is high 8 clk and low 12 clk; done every 20 clk. Without the macro, CTRL[15:8] reads 0 after writing 8'h03.
